// File: rtl/rr_slot_arbiter_if.sv
// Request/grant bundle between requesters (master) and rr_slot_arbiter (slave).
interface rr_slot_arbiter_if;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;
    logic [ID_W-1:0]  ptr;
    logic             preempt;

    modport master (
        output req,
        input  gnt, gnt_id, gnt_valid, ptr, preempt
    );

    modport slave (
        input  req,
        output gnt, gnt_id, gnt_valid, ptr, preempt
    );
endinterface

// File: rtl/rr_slot_arbiter.sv
// Four-way round-robin arbiter with a one-cycle turnaround gap after every grant.
// Optional tenure limit with forced release when ARB_PREEMPT_EN is defined.
module rr_slot_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    rr_slot_arbiter_if.slave bus
);
    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Reject configurations where the tenure counter cannot reach MAX_HOLD.
    if (MAX_HOLD == 0 || MAX_HOLD > 255 || (MAX_HOLD >> HOLD_W) != 0) begin : g_bad_cfg
        $error("rr_slot_arbiter: MAX_HOLD must be 1..255 and below 2**HOLD_W");
    end

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   win_id;
    logic              win_found;
`ifdef ARB_PREEMPT_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              preempt_q, preempt_d;
`endif

    // First requester found scanning upward from the priority pointer.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && bus.req[ptr_q + ID_W'(i)]) begin
                win_found = 1'b1;
                win_id    = ptr_q + ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
`ifdef ARB_PREEMPT_EN
        hold_d      = hold_q;
        preempt_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = BUSY;
                    gnt_d       = N_REQ'(1) << win_id;
                    gnt_id_d    = win_id;
                    gnt_valid_d = 1'b1;
`ifdef ARB_PREEMPT_EN
                    hold_d      = HOLD_W'(1);
`endif
                end
            end
            BUSY: begin
                // Release on request drop (or tenure expiry); winner drops to lowest priority.
                if (!bus.req[gnt_id_q]) begin
                    state_d     = GAP;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q + ID_W'(1);
`ifdef ARB_PREEMPT_EN
                    hold_d      = '0;
                end else if (hold_q >= HOLD_W'(MAX_HOLD)) begin
                    state_d     = GAP;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q + ID_W'(1);
                    hold_d      = '0;
                    preempt_d   = 1'b1;
                end else if (hold_q != '1) begin
                    hold_d      = hold_q + HOLD_W'(1);
`endif
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
`ifdef ARB_PREEMPT_EN
            hold_q      <= '0;
            preempt_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
`ifdef ARB_PREEMPT_EN
            hold_q      <= hold_d;
            preempt_q   <= preempt_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.ptr       = ptr_q;
`ifdef ARB_PREEMPT_EN
    assign bus.preempt   = preempt_q;
`else
    assign bus.preempt   = 1'b0;
`endif
endmodule

// File: doc/rr_slot_arbiter.md
Name: rr_slot_arbiter

Overview:
- Round-robin arbiter sharing one resource among 4 requesters. It uses a 2-bit wrap-around priority pointer, the same 0..3 count sequence as the team's 2-bit counter.
- Sits in front of a shared datapath. It grants exactly one requester at a time and keeps that grant while the requester holds its request.
- Guarantees fairness: after a grant, the winner becomes lowest priority.

Parameters:
- MAX_HOLD, 8, maximum grant tenure in cycles before forced release (used only with ARB_PREEMPT_EN); legal range 1..255.
- HOLD_W, 8, width of the tenure counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit i = requester i.
- gnt  output  4  one-hot grant vector; all-zero when the resource is idle.
- gnt_id  output  2  index of the current grantee; 0 when gnt==0.
- gnt_valid  output  1  high whenever gnt!=0.
- ptr  output  2  current highest-priority index.
- preempt  output  1  one-cycle pulse when a grant is force-released (only with ARB_PREEMPT_EN).

Behaviour:
- Reset (async, asserted): gnt=0, gnt_id=0, gnt_valid=0, ptr=0, preempt=0, hold counter=0, state=IDLE. Reset asserted mid-grant drops gnt immediately, without waiting for clk.
- States: IDLE, BUSY, GAP. All outputs are registered.
- IDLE:
  - If req!=0 at a rising edge, pick the winner w by scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
  - Next cycle: gnt=1<<w, gnt_id=w, gnt_valid=1, hold counter=1, state→BUSY.
  - Latency is 1 cycle from req sampled to gnt visible.
  - If req==0, stay in IDLE; ptr is unchanged.
- BUSY:
  - While req[gnt_id]=1, keep the grant and increment the hold counter.
  - When req[gnt_id]=0 at an edge: gnt→0 on the next cycle, ptr←gnt_id+1 (3 wraps to 0), state→GAP.
  - Requests from other requesters are ignored while BUSY; there is no mid-tenure switching.
- GAP:
  - Exactly one dead cycle with gnt=0 (bus turnaround). Then state→IDLE, and arbitration resumes at the next edge.
  - Minimum spacing between two grants is therefore 2 cycles of gnt=0 edges, i.e. the next grant appears 2 cycles after release.
- Arithmetic: ptr and gnt_id are 2-bit modulo-4; the increment from 3 wraps to 0.
  - The hold counter saturates at 2^HOLD_W-1 and never wraps.
- Boundaries:
  - All 4 requesting with ptr=k: the grant order is k, k+1, k+2, k+3 mod 4.
  - A single persistent requester is re-granted after every GAP.
  - A request deasserted and reasserted in the same cycle as release is treated as a new request, and it has lowest priority (ptr has advanced past it).
  - A req bit falling during IDLE before being sampled produces no grant.
  - X/undefined req is not supported.
- Invariant: popcount(gnt) ≤ 1 in all cycles.

Optional Feature:
- Macro: ARB_PREEMPT_EN.
- Defined: in BUSY, when the hold counter reaches MAX_HOLD with req[gnt_id] still 1:
  - the grant is forced off on the next cycle;
  - preempt pulses high for that one cycle;
  - ptr←gnt_id+1;
  - state→GAP.
  - The preempted requester must re-arbitrate and gets lowest priority.
- Not defined: there is no tenure limit; the grant is held until req drops; the preempt output is tied 0; the hold counter may be removed.

Test Plan:
- Reset: assert rst mid-grant (gnt=4'b0100) with no clock edge → gnt=0, gnt_id=0, ptr=0 immediately; release rst, req=4'b0000 → outputs stay 0.
- Single requester: req=4'b0010 held 3 cycles then dropped → gnt=4'b0010 from cycle 1 for 3 cycles; gnt=0 for 2 cycles; ptr=2.
- Full contention: ptr=0, req=4'b1111, each requester holds 2 cycles then drops for 1 → grant order 0,1,2,3,0; ptr follows 1,2,3,0,1.
- Wrap: ptr=3, req=4'b1001 → requester 3 granted first, then 0; ptr goes 3→0→1.
- Busy ignore: requester 1 granted, req[2] rises mid-tenure → gnt stays 4'b0010 until req[1] drops; requester 2 granted after GAP.
- Preempt (ARB_PREEMPT_EN, MAX_HOLD=8): req[0] held 20 cycles, req[3]=1 → gnt[0] high for exactly 8 cycles; preempt pulses once; after GAP, gnt=4'b1000.
